eth_frame_arbiter: RTL and testbench

ETH_FRAME_ARBITER -- requirements
Module: eth_frame_arbiter

---
 rtl/eth_pkg.sv | 6 +
 rtl/rr_select.sv | 22 ++
 rtl/eth_frame_arbiter.sv | 106 ++++++++++
 tb/tb_eth_frame_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared widths and arbiter state encoding for the Ethernet frame arbiter.
package eth_pkg;
   localparam int MAC_WIDTH = 48;
   localparam int ETHTYPE_WIDTH = 16;
   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} arb_state_t;
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin picker, first requester at or after ptr (wrapping).
module rr_select #(
   parameter int N_PORTS = 2,
   parameter int PORT_BITS = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0]   req,
   input  logic [PORT_BITS-1:0] ptr,
   output logic [PORT_BITS-1:0] idx,
   output logic                 found
);
   always_comb begin
      idx = '0;
      found = 1'b0;
      // Scan from the farthest offset down so the nearest requester wins.
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N_PORTS]) begin
            idx = PORT_BITS'((int'(ptr) + k) % N_PORTS);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/eth_frame_arbiter.sv
// eth_frame_arbiter: round-robin, frame-atomic arbiter of N header+payload sources onto one output.
// Defining ETH_FRAME_ARBITER_STATS_EN adds per-port completed-frame counters on frame_count.
module eth_frame_arbiter
   import eth_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int DATA_WIDTH = 8,
   parameter int PORT_BITS = $clog2(N_PORTS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_PORTS-1:0]               s_eth_hdr_valid,
   output logic [N_PORTS-1:0]               s_eth_hdr_ready,
   input  logic [MAC_WIDTH*N_PORTS-1:0]     s_eth_dest_mac,
   input  logic [MAC_WIDTH*N_PORTS-1:0]     s_eth_src_mac,
   input  logic [ETHTYPE_WIDTH*N_PORTS-1:0] s_eth_type,
   input  logic [DATA_WIDTH*N_PORTS-1:0]    s_eth_payload_axis_tdata,
   input  logic [N_PORTS-1:0]               s_eth_payload_axis_tvalid,
   output logic [N_PORTS-1:0]               s_eth_payload_axis_tready,
   input  logic [N_PORTS-1:0]               s_eth_payload_axis_tlast,
   input  logic [N_PORTS-1:0]               s_eth_payload_axis_tuser,
   output logic                             m_eth_hdr_valid,
   input  logic                             m_eth_hdr_ready,
   output logic [MAC_WIDTH-1:0]             m_eth_dest_mac,
   output logic [MAC_WIDTH-1:0]             m_eth_src_mac,
   output logic [ETHTYPE_WIDTH-1:0]         m_eth_type,
   output logic [DATA_WIDTH-1:0]            m_eth_payload_axis_tdata,
   output logic                             m_eth_payload_axis_tvalid,
   input  logic                             m_eth_payload_axis_tready,
   output logic                             m_eth_payload_axis_tlast,
   output logic                             m_eth_payload_axis_tuser,
   output logic                             grant_valid,
   output logic [PORT_BITS-1:0]             grant_port
`ifdef ETH_FRAME_ARBITER_STATS_EN
   ,
   output logic [32*N_PORTS-1:0]            frame_count
`endif
);
   arb_state_t state, state_nx;
   logic [PORT_BITS-1:0] rr_ptr, sel_idx;
   logic [N_PORTS-1:0] g_onehot;
   logic sel_found, hdr_fire, last_fire;

   rr_select #(.N_PORTS(N_PORTS), .PORT_BITS(PORT_BITS)) u_rr_select (
      .req(s_eth_hdr_valid),
      .ptr(rr_ptr),
      .idx(sel_idx),
      .found(sel_found)
   );

   assign g_onehot = N_PORTS'(1) << grant_port;
   assign hdr_fire = m_eth_hdr_valid & m_eth_hdr_ready;
   assign last_fire = m_eth_payload_axis_tvalid & m_eth_payload_axis_tready & m_eth_payload_axis_tlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rr_ptr <= '0;
         grant_port <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && sel_found) grant_port <= sel_idx;
         if (last_fire) rr_ptr <= (grant_port == PORT_BITS'(N_PORTS - 1)) ? '0 : grant_port + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (sel_found) state_nx = HDR;
         HDR:     if (hdr_fire) state_nx = PAYLOAD;
         PAYLOAD: if (last_fire) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      grant_valid = state != IDLE;
      m_eth_hdr_valid = (state == HDR) && |(s_eth_hdr_valid & g_onehot);
      m_eth_dest_mac = s_eth_dest_mac[grant_port*MAC_WIDTH +: MAC_WIDTH];
      m_eth_src_mac = s_eth_src_mac[grant_port*MAC_WIDTH +: MAC_WIDTH];
      m_eth_type = s_eth_type[grant_port*ETHTYPE_WIDTH +: ETHTYPE_WIDTH];
      s_eth_hdr_ready = (state == HDR && m_eth_hdr_ready) ? g_onehot : '0;
      m_eth_payload_axis_tvalid = (state == PAYLOAD) && |(s_eth_payload_axis_tvalid & g_onehot);
      m_eth_payload_axis_tdata = s_eth_payload_axis_tdata[grant_port*DATA_WIDTH +: DATA_WIDTH];
      m_eth_payload_axis_tlast = |(s_eth_payload_axis_tlast & g_onehot);
      m_eth_payload_axis_tuser = |(s_eth_payload_axis_tuser & g_onehot);
      s_eth_payload_axis_tready = (state == PAYLOAD && m_eth_payload_axis_tready) ? g_onehot : '0;
   end

`ifdef ETH_FRAME_ARBITER_STATS_EN
   logic [31:0] frame_cnt [N_PORTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PORTS; i++) frame_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_PORTS; i++) if (last_fire && g_onehot[i]) frame_cnt[i] <= frame_cnt[i] + 32'd1;
      end
   end

   for (genvar i = 0; i < N_PORTS; i++) begin : g_cnt
      assign frame_count[i*32 +: 32] = frame_cnt[i];
   end
`endif
endmodule

// File: tb/tb_eth_frame_arbiter.sv
// tb_eth_frame_arbiter: randomized self-checking bench with a queue-based round-robin frame model.
module tb_eth_frame_arbiter;
   localparam int N = 4;
   localparam int DW = 8;
   localparam int PB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] s_hdr_valid, s_hdr_ready, s_tvalid, s_tready, s_tlast, s_tuser;
   logic [48*N-1:0] s_dst, s_src;
   logic [16*N-1:0] s_type;
   logic [DW*N-1:0] s_tdata;
   logic m_hdr_valid, m_hdr_ready, m_tvalid, m_tready, m_tlast, m_tuser, grant_valid;
   logic [47:0] m_dst, m_src;
   logic [15:0] m_type;
   logic [DW-1:0] m_tdata;
   logic [PB-1:0] grant_port;
`ifdef ETH_FRAME_ARBITER_STATS_EN
   logic [32*N-1:0] frame_count;
`endif

   eth_frame_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
      .s_eth_dest_mac(s_dst), .s_eth_src_mac(s_src), .s_eth_type(s_type),
      .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(s_tvalid),
      .s_eth_payload_axis_tready(s_tready), .s_eth_payload_axis_tlast(s_tlast),
      .s_eth_payload_axis_tuser(s_tuser),
      .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
      .m_eth_dest_mac(m_dst), .m_eth_src_mac(m_src), .m_eth_type(m_type),
      .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tvalid(m_tvalid),
      .m_eth_payload_axis_tready(m_tready), .m_eth_payload_axis_tlast(m_tlast),
      .m_eth_payload_axis_tuser(m_tuser),
      .grant_valid(grant_valid), .grant_port(grant_port)
`ifdef ETH_FRAME_ARBITER_STATS_EN
      , .frame_count(frame_count)
`endif
   );

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] typ;
      int len;
      logic [7:0] base;
      logic user;
   } frame_t;

   frame_t src_q [N][$];
   frame_t exp_q [N][$];
   int pos [N];
   bit in_pay [N];
   int done_cnt [N];
   int mptr;
   int hdr_mode, t_mode;
   bit throttle;
   int checks = 0;
   int errors = 0;

   task automatic enqueue(input int p, input int len);
      frame_t f;
      f.dst = {16'($urandom), $urandom};
      f.src = {16'($urandom), $urandom};
      f.typ = 16'($urandom);
      f.len = len;
      f.base = 8'($urandom);
      f.user = 1'($urandom);
      src_q[p].push_back(f);
      exp_q[p].push_back(f);
   endtask

   task automatic drive();
      frame_t f;
      for (int p = 0; p < N; p++) begin
         if (src_q[p].size() > 0) begin
            f = src_q[p][0];
            s_hdr_valid[p] = !in_pay[p];
            s_dst[p*48 +: 48] = f.dst;
            s_src[p*48 +: 48] = f.src;
            s_type[p*16 +: 16] = f.typ;
            s_tdata[p*DW +: DW] = f.base + 8'(pos[p]);
            s_tlast[p] = pos[p] == f.len - 1;
            s_tuser[p] = (pos[p] == f.len - 1) & f.user;
            s_tvalid[p] = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
         end else begin
            s_hdr_valid[p] = 1'b0;
            s_tvalid[p] = 1'b0;
            s_tlast[p] = 1'b0;
            s_tuser[p] = 1'b0;
         end
      end
      m_hdr_ready = hdr_mode == 0 ? 1'b1 : hdr_mode == 1 ? !m_hdr_ready : 1'($urandom);
      m_tready = t_mode == 0 ? 1'b1 : t_mode == 1 ? !m_tready : 1'($urandom);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int p = 0; p < N; p++) begin
         src_q[p].delete();
         exp_q[p].delete();
         pos[p] = 0;
         in_pay[p] = 1'b0;
         done_cnt[p] = 0;
      end
      s_hdr_valid = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
      s_dst = '0; s_src = '0; s_type = '0; s_tdata = '0;
      m_hdr_ready = 1'b0; m_tready = 1'b0;
      hdr_mode = 0; t_mode = 0; throttle = 1'b0;
      mptr = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Runs queued frames through the DUT; stops early after stop_beats output beats when nonzero.
   task automatic run(input int budget, input int stop_beats);
      int order[$];
      int pend [N];
      bit hf [N];
      bit bf [N];
      frame_t cur;
      int nexp, ep, cur_beat, cyc, last_end, beats, fin, gv_bad, ng_bad, gap_bad;
      bit in_frame, owner, ended, el;
      logic [7:0] ed;
      nexp = 0;
      for (int p = 0; p < N; p++) begin
         pend[p] = src_q[p].size();
         nexp += pend[p];
      end
      for (int n = 0; n < nexp; n++) begin
         for (int k = 0; k < N; k++) begin
            if (pend[(mptr + k) % N] > 0) begin
               ep = (mptr + k) % N;
               order.push_back(ep);
               pend[ep]--;
               mptr = (ep + 1) % N;
               break;
            end
         end
      end
      cur_beat = 0; cyc = 0; last_end = -1; beats = 0; fin = 0; ep = 0;
      gv_bad = 0; ng_bad = 0; gap_bad = 0; in_frame = 0; owner = 0; ended = 0;
      @(posedge clk);
      #1 drive();
      while (cyc < budget) begin
         @(negedge clk);
         if (grant_valid !== (owner | m_hdr_valid)) gv_bad++;
         for (int p = 0; p < N; p++)
            if ((s_hdr_ready[p] || s_tready[p]) && (!grant_valid || p != int'(grant_port))) ng_bad++;
         if (m_hdr_valid && !owner) begin
            owner = 1;
            if (cyc != (last_end < 0 ? 1 : last_end + 2)) gap_bad++;
         end
         if (m_hdr_valid && m_hdr_ready) begin
            checks++;
            if (order.size() == 0) begin
               errors++;
               $display("FAIL extra_hdr: header fired with no frame expected, port %0d", grant_port);
            end else begin
               ep = order.pop_front();
               cur = exp_q[ep].pop_front();
               cur_beat = 0;
               in_frame = 1;
               if (grant_port !== PB'(ep)) begin
                  errors++;
                  $display("FAIL grant_order: grant_port=%0d expected %0d", grant_port, ep);
               end
               checks++;
               if ({m_dst, m_src, m_type} !== {cur.dst, cur.src, cur.typ}) begin
                  errors++;
                  $display("FAIL hdr_fields: got %h/%h/%h expected %h/%h/%h", m_dst, m_src, m_type, cur.dst, cur.src, cur.typ);
               end
            end
         end
         if (m_tvalid && m_tready) begin
            beats++;
            checks++;
            if (!in_frame) begin
               errors++;
               $display("FAIL beat_before_hdr: beat %h accepted with no header fired", m_tdata);
            end else begin
               ed = cur.base + 8'(cur_beat);
               el = cur_beat == cur.len - 1;
               if (m_tdata !== ed || m_tlast !== el || m_tuser !== (el & cur.user)) begin
                  errors++;
                  $display("FAIL beat: port %0d beat %0d got data=%h last=%b user=%b expected data=%h last=%b user=%b",
                           ep, cur_beat, m_tdata, m_tlast, m_tuser, ed, el, el & cur.user);
               end
               cur_beat++;
               if (el) begin
                  in_frame = 0;
                  owner = 0;
                  last_end = cyc;
                  done_cnt[ep]++;
                  fin++;
               end
            end
         end
         for (int p = 0; p < N; p++) begin
            hf[p] = s_hdr_valid[p] & s_hdr_ready[p];
            bf[p] = s_tvalid[p] & s_tready[p];
         end
         @(posedge clk);
         #1;
         for (int p = 0; p < N; p++) begin
            if (hf[p]) in_pay[p] = 1'b1;
            if (bf[p]) begin
               if (pos[p] == src_q[p][0].len - 1) begin
                  void'(src_q[p].pop_front());
                  pos[p] = 0;
                  in_pay[p] = 1'b0;
               end else pos[p]++;
            end
         end
         drive();
         cyc++;
         if ((stop_beats == 0 && fin == nexp && !in_frame) || (stop_beats > 0 && beats >= stop_beats)) begin
            ended = 1;
            break;
         end
      end
      checks++;
      if (!ended) begin
         errors++;
         $display("FAIL timeout: %0d of %0d frames after %0d cycles", fin, nexp, budget);
      end
      checks++;
      if (gv_bad != 0) begin
         errors++;
         $display("FAIL grant_valid: %0d cycles wrong, expected 0", gv_bad);
      end
      checks++;
      if (ng_bad != 0) begin
         errors++;
         $display("FAIL ungranted_ready: %0d cycles with ready to a non-owner, expected 0", ng_bad);
      end
      checks++;
      if (gap_bad != 0) begin
         errors++;
         $display("FAIL hdr_latency: %0d headers off the 1-cycle request/idle timing, expected 0", gap_bad);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s_hdr_valid = '1; s_tvalid = '1; m_hdr_ready = 1'b1; m_tready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (grant_valid !== 1'b0 || grant_port !== '0) begin
         errors++;
         $display("FAIL reset_grant: valid=%b port=%0d expected 0/0", grant_valid, grant_port);
      end
      checks++;
      if (m_hdr_valid !== 1'b0 || m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_m_valid: hdr=%b tvalid=%b expected 0/0", m_hdr_valid, m_tvalid);
      end
      checks++;
      if (s_hdr_ready !== '0 || s_tready !== '0) begin
         errors++;
         $display("FAIL reset_s_ready: hdr=%b tready=%b expected 0/0", s_hdr_ready, s_tready);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      repeat (3) enqueue(0, 4);
      run(500, 0);
   endtask

   task automatic test_two_ports();
      do_reset();
      repeat (2) begin
         enqueue(0, 3);
         enqueue(1, 3);
      end
      run(500, 0);
   endtask

   task automatic test_tready_toggle();
      do_reset();
      t_mode = 1;
      enqueue(0, 5);
      enqueue(1, 4);
      run(500, 0);
   endtask

   task automatic test_wrap();
      do_reset();
      enqueue(3, 2);
      run(200, 0);
      enqueue(3, 2);
      enqueue(0, 2);
      run(200, 0);
   endtask

   task automatic test_hold();
      int bad;
      do_reset();
      @(posedge clk);
      #1 s_hdr_valid = 4'b0100;
      @(negedge clk);
      checks++;
      if (m_hdr_valid !== 1'b0 || grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_early: hdr_valid=%b grant_valid=%b expected 0/0", m_hdr_valid, grant_valid);
      end
      @(negedge clk);
      checks++;
      if (m_hdr_valid !== 1'b1 || grant_port !== 2'd2) begin
         errors++;
         $display("FAIL hold_grant: hdr_valid=%b port=%0d expected 1/2", m_hdr_valid, grant_port);
      end
      @(posedge clk);
      #1 s_hdr_valid = 4'b0010;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (grant_valid !== 1'b1 || grant_port !== 2'd2 || m_hdr_valid !== 1'b0 || s_hdr_ready !== '0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_keep: %0d cycles lost the withdrawn grant, expected 0", bad);
      end
      @(posedge clk);
      #1 begin s_hdr_valid = 4'b0110; m_hdr_ready = 1'b1; end
      @(negedge clk);
      checks++;
      if (m_hdr_valid !== 1'b1 || grant_port !== 2'd2 || s_hdr_ready !== 4'b0100) begin
         errors++;
         $display("FAIL hold_resume: hdr_valid=%b port=%0d ready=%b expected 1/2/0100", m_hdr_valid, grant_port, s_hdr_ready);
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      do_reset();
      enqueue(1, 5);
      run(200, 1);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_beat2: tvalid=%b expected 1", m_tvalid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({m_hdr_valid, m_tvalid, grant_valid} !== 3'b000 || s_tready !== '0 || s_hdr_ready !== '0 || grant_port !== '0) begin
         errors++;
         $display("FAIL mid_async_reset: hdr=%b tvalid=%b gv=%b tready=%b hready=%b port=%0d expected all 0",
                  m_hdr_valid, m_tvalid, grant_valid, s_tready, s_hdr_ready, grant_port);
      end
      do_reset();
      enqueue(3, 2);
      enqueue(0, 2);
      run(200, 0);
   endtask

   task automatic test_random();
      do_reset();
      hdr_mode = 2; t_mode = 2; throttle = 1'b1;
      repeat (4) begin
         for (int p = 0; p < N; p++)
            repeat ($urandom_range(0, 3)) enqueue(p, $urandom_range(1, 6));
         run(3000, 0);
`ifdef ETH_FRAME_ARBITER_STATS_EN
         for (int p = 0; p < N; p++) begin
            checks++;
            if (frame_count[p*32 +: 32] !== 32'(done_cnt[p])) begin
               errors++;
               $display("FAIL rand_frame_count: port %0d got %0d expected %0d", p, frame_count[p*32 +: 32], done_cnt[p]);
            end
         end
`endif
      end
   endtask

   task automatic test_stats();
`ifdef ETH_FRAME_ARBITER_STATS_EN
      do_reset();
      repeat (5) enqueue(0, 2);
      repeat (2) enqueue(1, 3);
      run(1000, 0);
      checks++;
      if (frame_count[31:0] !== 32'd5 || frame_count[63:32] !== 32'd2 || frame_count[127:64] !== '0) begin
         errors++;
         $display("FAIL frame_count: got %0d,%0d,%0d,%0d expected 5,2,0,0",
                  frame_count[31:0], frame_count[63:32], frame_count[95:64], frame_count[127:96]);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_ports();
      test_tready_toggle();
      test_wrap();
      test_hold();
      test_reset_mid();
      test_random();
      test_stats();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
